// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared state encoding, default width and the floor-root reference function
package sqrt_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} sqrt_state_t;

    localparam int SQRT_WIDTH = 32;

    function automatic logic [15:0] sqrt_ref(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] c;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            c = r | (16'd1 << i);
            if ({16'd0, c} * {16'd0, c} <= x) r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/sqrt_step.sv
// sqrt_step: one combinational restoring digit-by-digit square-root iteration
module sqrt_step #(
    parameter int ITER = 16
) (
    input  logic [ITER+1:0] rem_i,
    input  logic [ITER-1:0] acc_i,
    input  logic [1:0]      x_top,
    output logic [ITER+1:0] rem_o,
    output logic [ITER-1:0] acc_o
);

    logic [ITER+3:0] rem_w;
    logic [ITER+1:0] trial;
    logic            ge;

    // bring down two radicand bits, subtract the trial divisor when it fits
    always_comb begin
        rem_w = {rem_i, x_top};
        trial = {acc_i, 2'b01};
        ge    = rem_w >= {2'b00, trial};
        rem_o = ge ? rem_w[ITER+1:0] - trial : rem_w[ITER+1:0];
        acc_o = {acc_i[ITER-2:0], ge};
    end

endmodule

// File: rtl/sqrt_iter_core.sv
// sqrt_iter_core: iterative floor square root, one result bit per clock; SQRT_REMAINDER_EN adds remainder/exact outputs
module sqrt_iter_core import sqrt_pkg::*; #(
    parameter  int WIDTH = SQRT_WIDTH,
    localparam int ITER  = WIDTH / 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] radicand,
    output logic [WIDTH-1:0] root,
    output logic             busy,
`ifdef SQRT_REMAINDER_EN
    output logic             done,
    output logic [ITER:0]    remainder,
    output logic             exact
`else
    output logic             done
`endif
);

    localparam int CW = $clog2(ITER);

    sqrt_state_t      state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d, root_q, root_d;
    logic [ITER+1:0]  rem_q, rem_d, rem_n;
    logic [ITER-1:0]  acc_q, acc_d, acc_n;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             load, calc, last;
`ifdef SQRT_REMAINDER_EN
    logic [ITER:0]    remainder_q, remainder_d;
    logic             exact_q, exact_d;
`endif

    sqrt_step #(.ITER(ITER)) u_step (
        .rem_i (rem_q),
        .acc_i (acc_q),
        .x_top (x_q[WIDTH-1:WIDTH-2]),
        .rem_o (rem_n),
        .acc_o (acc_n)
    );

    // next-state: accept start whenever not calculating, iterate in CALC, publish results on the last step
    always_comb begin
        load    = start && state_q != CALC;
        calc    = state_q == CALC;
        last    = calc && cnt_q == '0;
        state_d = load ? CALC : (calc && !last) ? CALC : last ? DONE : IDLE;
        x_d     = load ? radicand : calc ? x_q << 2 : x_q;
        rem_d   = load ? '0 : calc ? rem_n : rem_q;
        acc_d   = load ? '0 : calc ? acc_n : acc_q;
        cnt_d   = load ? CW'(ITER - 1) : calc ? cnt_q - CW'(1) : cnt_q;
        root_d  = last ? {{(WIDTH-ITER){1'b0}}, acc_n} : root_q;
        busy_d  = state_d == CALC;
        done_d  = state_d == DONE;
`ifdef SQRT_REMAINDER_EN
        remainder_d = last ? rem_n[ITER:0] : remainder_q;
        exact_d     = last ? rem_n[ITER:0] == '0 : exact_q;
`endif
    end

    // state and registered outputs, cleared asynchronously
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            rem_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            root_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SQRT_REMAINDER_EN
            remainder_q <= '0;
            exact_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            root_q  <= root_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SQRT_REMAINDER_EN
            remainder_q <= remainder_d;
            exact_q     <= exact_d;
`endif
        end
    end

    assign root = root_q;
    assign busy = busy_q;
    assign done = done_q;
`ifdef SQRT_REMAINDER_EN
    assign remainder = remainder_q;
    assign exact     = exact_q;
`endif

endmodule

// File: tb/tb_sqrt_iter_core.sv
// tb_sqrt_iter_core: scoreboard bench for sqrt_iter_core, directed cases plus random radicands
module tb_sqrt_iter_core;
    import sqrt_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] radicand;
    logic [31:0] root;
    logic        busy;
    logic        done;
`ifdef SQRT_REMAINDER_EN
    logic [16:0] remainder;
    logic        exact;
`endif

    sqrt_iter_core dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .radicand (radicand),
        .root     (root),
        .busy     (busy),
`ifdef SQRT_REMAINDER_EN
        .done     (done),
        .remainder(remainder),
        .exact    (exact)
`else
        .done     (done)
`endif
    );

    typedef struct {
        logic [31:0] x;
        logic [15:0] r;
        logic [16:0] rem;
        int unsigned due;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned busy_run = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [16:0] rem_of(input logic [31:0] x);
        logic [63:0] r;
        r = 64'(sqrt_ref(x));
        return 17'(64'(x) - r * r);
    endfunction

    task automatic push(input logic [31:0] x, input logic [15:0] r, input logic [16:0] rem, input int unsigned due);
        exp_t e;
        e.x = x;
        e.r = r;
        e.rem = rem;
        e.due = due;
        q.push_back(e);
    endtask

    // called at a falling edge; one-cycle start pulse, expectation queued only if the core will accept it
    task automatic issue(input logic [31:0] x, input logic [15:0] r, input logic [16:0] rem, input bit acc);
        start = 1'b1;
        radicand = x;
        if (acc) push(x, r, rem, cyc + 17);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue_rand(input logic [31:0] x);
        issue(x, sqrt_ref(x), rem_of(x), 1'b1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: no done within 40 cycles (t=%0t)", $time);
        end
    endtask

    initial begin
        exp_t        e;
        logic [63:0] r64;
        forever begin
            @(negedge clk);
            if (!reset_n) busy_run = 0;
            else begin
                if (busy) busy_run++;
                if (done) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_done: done with nothing outstanding, root=%0h", root);
                    end else begin
                        e = q.pop_front();
                        r64 = 64'(root);
                        chk("root", 64'(root), 64'(e.r));
                        chk("root_bound", 64'(r64 * r64 <= 64'(e.x) && (r64 + 1) * (r64 + 1) > 64'(e.x)), 64'd1);
                        chk("latency", 64'(cyc), 64'(e.due));
                        chk("busy_cycles", 64'(busy_run), 64'd16);
                        chk("busy_in_done", 64'(busy), 64'd0);
`ifdef SQRT_REMAINDER_EN
                        chk("remainder", 64'(remainder), 64'(e.rem));
                        chk("exact", 64'(exact), 64'(e.rem == 17'd0));
`endif
                    end
                    busy_run = 0;
                end
            end
        end
    end

    initial begin
        logic [31:0] x;
        start = 1'b0;
        radicand = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_root", 64'(root), 64'd0);
`ifdef SQRT_REMAINDER_EN
        chk("reset_remainder", 64'(remainder), 64'd0);
        chk("reset_exact", 64'(exact), 64'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);
        issue(32'd0, 16'd0, 17'd0, 1'b1);                 wait_done(); @(negedge clk);
        issue(32'd1000000, 16'd1000, 17'd0, 1'b1);        wait_done(); @(negedge clk);
        issue(32'd15, 16'd3, 17'd6, 1'b1);                wait_done(); @(negedge clk);
        issue(32'hFFFF_FFFF, 16'hFFFF, 17'h1FFFE, 1'b1);  wait_done(); @(negedge clk);
        issue(32'd1, 16'd1, 17'd0, 1'b1);                 wait_done(); @(negedge clk);
        issue(32'd99, 16'd9, 17'd18, 1'b1);
        repeat (3) @(negedge clk);
        issue(32'h10000, 16'd0, 17'd0, 1'b0);
        wait_done();
        @(negedge clk);
        start = 1'b1;
        radicand = 32'd25;
        push(32'd25, 16'd5, 17'd0, cyc + 17);
        push(32'd25, 16'd5, 17'd0, cyc + 34);
        repeat (20) @(negedge clk);
        start = 1'b0;
        wait_done();
        @(negedge clk);
        issue(32'd50, 16'd7, 17'd1, 1'b1);
        wait_done();
        issue(32'd144, 16'd12, 17'd0, 1'b1);
        wait_done();
        @(negedge clk);
        issue(32'd1000, 16'd31, 17'd39, 1'b1);
        repeat (6) @(negedge clk);
        #1 reset_n = 1'b0;
        q.delete();
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_root", 64'(root), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        issue(32'd49, 16'd7, 17'd0, 1'b1);
        wait_done();
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            x = (i % 3 == 0) ? 32'($urandom_range(0, 2000)) : $urandom;
            issue_rand(x);
            if ($urandom_range(0, 1) == 1) begin
                repeat (4) @(negedge clk);
                issue($urandom, 16'd0, 17'd0, 1'b0);
            end
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
